// File: rtl/iomem_timer.sv
// ---------------------------------------------------------------------------
// iomem_timer
//
// Purpose:
//   Programmable 32-bit down-counting timer behind an iomem slave port.
//   A PRESCALE_W-bit prescaler produces a tick every PRESCALE+1 clocks while
//   enabled. Each tick decrements COUNT. A tick that finds COUNT already at
//   zero is an expire event. An expire event sets a sticky flag. It then
//   either reloads COUNT from RELOAD (auto mode) or stops the timer
//   (one-shot mode).
//
// Register map (address bits [7:2] decoded, bits [23:8] alias):
//   0x00 CTRL     bit0 en, bit1 auto, bit2 ie
//   0x04 PRESCALE prescaler compare value
//   0x08 RELOAD   auto-reload value
//   0x0C COUNT    live counter, writable
//   0x10 STATUS   bit0 flag, write-one-to-clear
//   others        read as zero, writes ignored
//
// Ports:
//   clock      in   single clock
//   reset      in   synchronous active-high reset, clears all state
//   valid      in   iomem request, held until ready is seen
//   ready      out  one-cycle acknowledge
//   address    in   byte address within the 0x04xx_xxxx window
//   write_data in   write data
//   wstrb      in   byte write strobes, all zero means read
//   read_data  out  registered read data, holds until the next access
//   irq        out  registered level interrupt, flag & ie
// ---------------------------------------------------------------------------
module iomem_timer #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [23:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  wstrb,
    output logic [31:0] read_data,
    output logic        irq
);

    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_PRESCALE = 6'h01;
    localparam logic [5:0] REG_RELOAD   = 6'h02;
    localparam logic [5:0] REG_COUNT    = 6'h03;
    localparam logic [5:0] REG_STATUS   = 6'h04;

    logic                  en_q, en_d;
    logic                  auto_q, auto_d;
    logic                  ie_q, ie_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           reload_q, reload_d;
    logic [31:0]           count_q, count_d;
    logic                  flag_q, flag_d;
    logic [PRESCALE_W-1:0] pc_q, pc_d;
    logic                  ready_q, ready_d;
    logic [31:0]           readData_q, readData_d;
    logic                  irq_q, irq_d;

    logic                  access;
    logic                  isWrite;
    logic [5:0]            regSel;
    logic                  ctrlWr, prescaleWr, reloadWr, countWr, statusWr;
    logic                  tick;
    logic                  expire;
    logic [31:0]           readMux;
    logic                  unusedAddr;

    // Only address bits [7:2] select a register; the rest alias the block.
    assign unusedAddr = ^{address[23:8], address[1:0]};

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = newVal[8*b +: 8];
            end
        end
        return result;
    endfunction

    // An access is accepted on the edge that raises ready. That is the
    // only edge on which writes commit and read data is captured.
    always_comb begin
        access     = valid && !ready_q;
        isWrite    = access && (wstrb != 4'b0000);
        regSel     = address[7:2];
        ctrlWr     = isWrite && (regSel == REG_CTRL);
        prescaleWr = isWrite && (regSel == REG_PRESCALE);
        reloadWr   = isWrite && (regSel == REG_RELOAD);
        countWr    = isWrite && (regSel == REG_COUNT);
        statusWr   = isWrite && (regSel == REG_STATUS);
    end

    // A tick that coincides with a COUNT write is discarded entirely, so it
    // cannot raise an expire event either.
    always_comb begin
        tick   = en_q && (pc_q == prescale_q);
        expire = tick && !countWr && (count_q == 32'd0);
    end

    // Read mux sees the pre-edge register values, so a read that shares an
    // edge with an internal update returns the old value.
    always_comb begin
        readMux = 32'd0;
        case (regSel)
            REG_CTRL:     readMux = {29'd0, ie_q, auto_q, en_q};
            REG_PRESCALE: readMux = 32'(prescale_q);
            REG_RELOAD:   readMux = reload_q;
            REG_COUNT:    readMux = count_q;
            REG_STATUS:   readMux = {31'd0, flag_q};
            default:      readMux = 32'd0;
        endcase
    end

    // Next-state logic. Later assignments take priority: a bus write beats
    // the one-shot auto-clear of en, a COUNT write beats a tick, and an
    // expire event beats a STATUS clear.
    always_comb begin
        en_d       = en_q;
        auto_d     = auto_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        flag_d     = flag_q;
        pc_d       = pc_q;

        if (en_q) begin
            pc_d = tick ? '0 : pc_q + 1'b1;
        end

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end
        end

        if (expire && !auto_q) begin
            en_d = 1'b0;
        end

        if (ctrlWr && wstrb[0]) begin
            en_d   = write_data[0];
            auto_d = write_data[1];
            ie_d   = write_data[2];
            if (!en_q && write_data[0]) begin
                pc_d = '0;
            end
        end

        if (prescaleWr) begin
            prescale_d = PRESCALE_W'(mergeBytes(32'(prescale_q), write_data, wstrb));
        end

        if (reloadWr) begin
            reload_d = mergeBytes(reload_q, write_data, wstrb);
        end

        if (countWr) begin
            count_d = mergeBytes(count_q, write_data, wstrb);
            pc_d    = '0;
        end

        if (statusWr && wstrb[0] && write_data[0]) begin
            flag_d = 1'b0;
        end
        if (expire) begin
            flag_d = 1'b1;
        end
    end

    // Bus-side outputs and interrupt. irq uses the next-state flag and ie,
    // so it changes on the same edge as they do but comes straight from a
    // flop.
    always_comb begin
        ready_d    = valid && !ready_q;
        readData_d = access ? readMux : readData_q;
        irq_d      = flag_d && ie_d;
    end

    // All state, including pending handshakes, is cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            prescale_q <= '0;
            reload_q   <= 32'd0;
            count_q    <= 32'd0;
            flag_q     <= 1'b0;
            pc_q       <= '0;
            ready_q    <= 1'b0;
            readData_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            flag_q     <= flag_d;
            pc_q       <= pc_d;
            ready_q    <= ready_d;
            readData_q <= readData_d;
            irq_q      <= irq_d;
        end
    end

    assign ready     = ready_q;
    assign read_data = readData_q;
    assign irq       = irq_q;

endmodule

// File: doc/iomem_timer.md
# iomem_timer

Programmable 32-bit down-counting timer with a 16-bit prescaler, auto-reload and a sticky expiry flag. It is an iomem slave decoded by the SoC top in the 0x04xx_xxxx window and replaces the current stub there, which answers every access with zero. Its `irq` output drives `picosoc.irq_5`, giving firmware periodic or one-shot interrupts without polling.

## Interface
Parameters:
- `PRESCALE_W`, default 16: prescaler register width.

Ports:
- `clock` in 1: the single clock for the block.
- `reset` in 1: synchronous, active-high; clears all state.
- `valid` in 1: iomem request. The top drives it as `iomem_valid && addr[31:24]==8'h04`.
- `ready` out 1: one-cycle acknowledge.
- `address` in 24: byte address; only bits [7:2] are decoded.
- `write_data` in 32: write data.
- `wstrb` in 4: byte write strobes; all zero means a read.
- `read_data` out 32: read data, valid while `ready` is high.
- `irq` out 1: level interrupt, equal to `flag & CTRL.ie`.

## Operation
Register map (offset: name, fields):
- 0x00 CTRL: bit0 `en`, bit1 `auto`, bit2 `ie`; other bits read as 0.
- 0x04 PRESCALE: bits [PRESCALE_W-1:0].
- 0x08 RELOAD: 32 bits.
- 0x0C COUNT: 32 bits. Reads return the live count; writes load the counter.
- 0x10 STATUS: bit0 `flag`. Writing 1 clears it; writing 0 has no effect.
- 0x14–0xFC: unmapped. Reads return 0, writes are ignored, and `ready` is still given.

Byte strobes are honoured per byte on every register. Address bits [23:8] are ignored, so the register block aliases across the window.

Prescaler:
- Internal counter `pc` advances only while `en=1`.
- `tick` is asserted when `pc==PRESCALE`; on that cycle `pc` returns to 0. Otherwise `pc` increments.
- PRESCALE=0 therefore gives a tick every cycle. In general the period is PRESCALE+1 clocks.

Counter, on each tick:
- If COUNT≠0, COUNT decrements by 1.
- If COUNT==0, this is an expire event:
  - `flag` is set.
  - If `auto=1`, COUNT is loaded with RELOAD.
  - If `auto=0`, `en` clears and COUNT stays 0 (one-shot).
- The period is RELOAD+1 ticks. RELOAD=0 with `auto=1` expires on every tick.

Bus writes:
- A write to COUNT also sets `pc` to 0.
- A write that takes `en` from 0 to 1 sets `pc` to 0.
- A write with `en=0` freezes both `pc` and COUNT.

Simultaneous events:
- COUNT write and tick on the same cycle: the write wins and the tick is discarded.
- STATUS clear and expire event on the same cycle: set wins, so `flag` stays 1.
- CTRL write and one-shot auto-clear of `en` on the same cycle: the bus write wins.

Reset mid-operation: all registers, `pc`, `ready`, `read_data` and `irq` return to 0 on the next edge. Any pending access is dropped, and the master re-issues it.

## Timing
- Handshake: `ready <= valid && !ready`.
  - `ready` goes high the cycle after `valid` rises and stays high for exactly one cycle.
  - `valid` is held by the master until `ready` is seen.
  - Back-to-back accesses therefore complete at most once every 2 cycles.
- Writes commit on the same clock edge that raises `ready`.
- `read_data` is registered on that same edge. It returns the pre-write value if that edge also updates the register.
- `read_data` holds its value until the next access and is 0 after reset.
- `irq` is driven purely from flops, with no combinational path from bus inputs. It rises on the edge that sets `flag` (or `ie`) and falls on the edge that clears it.
- Reset value of every output: `ready`=0, `read_data`=0, `irq`=0.

## Test plan
- Periodic, prescaler 0. Setup: PRESCALE=0, RELOAD=3, COUNT=3, then CTRL=0x7 committed at edge E0. Expect:
  - COUNT reads 2, 1, 0 after E1, E2, E3.
  - `flag` and `irq` high after E4, with COUNT reloaded to 3.
  - Next expire after E8.
- One-shot with prescaler. Setup: PRESCALE=4, COUNT=1, CTRL=0x5. Expect:
  - Expire 10 cycles after enable.
  - CTRL then reads 0x4, COUNT stays 0 and no further `flag` sets after a clear.
- STATUS clear racing an expire. Setup: PRESCALE=0, RELOAD=0, auto mode; write 1 to STATUS on an expire edge. Expect `flag` still 1; a clear on a non-expire edge then works.
- Byte strobes. Setup: RELOAD=0xFFFFFFFF, then write 0x12345678 with `wstrb=0b0010`. Expect RELOAD reads 0xFFFF56FF.
- Handshake and unmapped offsets:
  - A read of 0x20 or 0x1014 returns 0 (0x1014 aliases to 0x14).
  - `ready` lasts exactly 1 cycle, and `valid` held for 5 cycles yields one `ready` per 2 cycles.
- Reset mid-count. Assert `reset` for 1 cycle while `en=1` and COUNT=100. Expect all registers to read 0, `irq`=0, and no tick afterwards.
